// File: rtl/uart_cmd_responder_if.sv
// Byte-level link between the command responder and its uart_rx/uart_tx pair.
interface uart_cmd_responder_if;
  logic [7:0] data_received;
  logic       rx_done;
  logic       parity_error;
  logic       tx_busy;
  logic [7:0] data_to_tx;
  logic       start_tx;

  // master is the UART side, slave is the responder
  modport master (
    output data_received, rx_done, parity_error, tx_busy,
    input  data_to_tx, start_tx
  );
  modport slave (
    input  data_received, rx_done, parity_error, tx_busy,
    output data_to_tx, start_tx
  );
endinterface

// File: rtl/uart_cmd_responder.sv
// Decodes stage on/off/toggle opcodes from FPGA_main, echoes each byte back,
// and forces the power stage off when the link goes quiet.
module uart_cmd_responder #(
  parameter int unsigned TIMEOUT    = 144000000,
  parameter int unsigned BUSY_WAIT  = 8,
  parameter logic [7:0]  CMD_ON     = 8'hEE,
  parameter logic [7:0]  CMD_OFF    = 8'h55,
  parameter logic [7:0]  CMD_TOGGLE = 8'hC3
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_cmd_responder_if.slave  uart,
  output logic                 stage_en,
  output logic [15:0]          cmd_count,
  output logic [7:0]           err_count,
  output logic                 overrun,
  output logic                 timeout_flag
);
  typedef enum logic [2:0] {IDLE, DECODE, TX_WAIT, TX_START, TX_ACK, TX_DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  byte_q, byte_d;
  logic [7:0]  pend_q, pend_d;
  logic        pend_full_q, pend_full_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        stage_q, stage_d;
  logic [15:0] cmd_cnt_q, cmd_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        overrun_q, overrun_d;
  logic        tmo_q, tmo_d;
  logic [31:0] wd_q, wd_d;
  logic [15:0] ack_q, ack_d;

  logic        rx_ok;
  logic        rx_bad;
  logic        is_cmd;
  logic        decode_cmd;
  logic [1:0]  err_inc;
  logic [8:0]  err_sum;
  logic [31:0] wd_inc;

  assign rx_ok      = uart.rx_done & ~uart.parity_error;
  assign rx_bad     = uart.rx_done & uart.parity_error;
  assign is_cmd     = (byte_q == CMD_ON) || (byte_q == CMD_OFF) || (byte_q == CMD_TOGGLE);
  assign decode_cmd = (state_q == DECODE) && is_cmd;
  assign wd_inc     = wd_q + 32'd1;

  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    tx_data_d   = tx_data_q;
    stage_d     = stage_q;
    cmd_cnt_d   = cmd_cnt_q;
    overrun_d   = overrun_q;
    tmo_d       = tmo_q;
    wd_d        = wd_q;
    ack_d       = ack_q;
    err_inc     = {1'b0, rx_bad};

    // Bytes arriving while the FSM is busy park in the one-deep buffer.
    if (rx_ok && (state_q != IDLE)) begin
      if (pend_full_q) begin
        overrun_d = 1'b1;
      end else begin
        pend_d      = uart.data_received;
        pend_full_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (pend_full_q) begin
          byte_d  = pend_q;
          state_d = DECODE;
          if (rx_ok) pend_d = uart.data_received;
          else       pend_full_d = 1'b0;
        end else if (rx_ok) begin
          byte_d  = uart.data_received;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (is_cmd) begin
          tx_data_d = byte_q;
          cmd_cnt_d = cmd_cnt_q + 16'd1;
        end else begin
          tx_data_d = ~byte_q;
          err_inc   = err_inc + 2'd1;
        end
        state_d = TX_WAIT;
      end
      TX_WAIT: begin
        if (!uart.tx_busy) state_d = TX_START;
      end
      TX_START: begin
        ack_d   = 16'd0;
        state_d = TX_ACK;
      end
      TX_ACK: begin
        if (uart.tx_busy) begin
          state_d = TX_DONE;
        end else if (ack_q == 16'(BUSY_WAIT - 1)) begin
          state_d = IDLE;
          err_inc = err_inc + 2'd1;
        end else begin
          ack_d = ack_q + 16'd1;
        end
      end
      TX_DONE: begin
        if (!uart.tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A valid command in DECODE takes priority over the watchdog firing.
    if (decode_cmd) begin
      wd_d  = 32'd0;
      tmo_d = 1'b0;
      if (byte_q == CMD_ON)       stage_d = 1'b1;
      else if (byte_q == CMD_OFF) stage_d = 1'b0;
      else                        stage_d = ~stage_q;
    end else if (!stage_q) begin
      wd_d = 32'd0;
    end else if (wd_inc >= TIMEOUT) begin
      stage_d = 1'b0;
      tmo_d   = 1'b1;
      wd_d    = 32'd0;
    end else begin
      wd_d = wd_inc;
    end

    err_sum   = {1'b0, err_cnt_q} + {7'd0, err_inc};
    err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      byte_q      <= 8'h00;
      pend_q      <= 8'h00;
      pend_full_q <= 1'b0;
      tx_data_q   <= 8'h00;
      stage_q     <= 1'b0;
      cmd_cnt_q   <= 16'd0;
      err_cnt_q   <= 8'd0;
      overrun_q   <= 1'b0;
      tmo_q       <= 1'b0;
      wd_q        <= 32'd0;
      ack_q       <= 16'd0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      tx_data_q   <= tx_data_d;
      stage_q     <= stage_d;
      cmd_cnt_q   <= cmd_cnt_d;
      err_cnt_q   <= err_cnt_d;
      overrun_q   <= overrun_d;
      tmo_q       <= tmo_d;
      wd_q        <= wd_d;
      ack_q       <= ack_d;
    end
  end

  assign uart.start_tx   = (state_q == TX_START);
  assign uart.data_to_tx = tx_data_q;
  assign stage_en        = stage_q;
  assign cmd_count       = cmd_cnt_q;
  assign err_count       = err_cnt_q;
  assign overrun         = overrun_q;
  assign timeout_flag    = tmo_q;
endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder: expected echoes go into a queue that an
// independent monitor drains on every start_tx pulse.
module tb_uart_cmd_responder;
  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic        stage_en;
  logic [15:0] cmd_count;
  logic [7:0]  err_count;
  logic        overrun;
  logic        timeout_flag;

  logic        hold_busy = 1'b0;
  logic        model_en  = 1'b1;
  logic [3:0]  busy_cnt;
  logic [7:0]  exp_b;
  logic [7:0]  sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_echo   = 0;
  int          e0;
  int          hi;

  uart_cmd_responder_if uif();

  uart_cmd_responder #(.TIMEOUT(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .uart         (uif),
    .stage_en     (stage_en),
    .cmd_count    (cmd_count),
    .err_count    (err_count),
    .overrun      (overrun),
    .timeout_flag (timeout_flag)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: busy for five cycles starting the edge after start_tx
  always @(posedge clk or posedge reset) begin
    if (reset)                          busy_cnt <= 4'd0;
    else if (uif.start_tx && model_en)  busy_cnt <= 4'd5;
    else if (busy_cnt != 4'd0)          busy_cnt <= busy_cnt - 4'd1;
  end
  assign uif.tx_busy = (busy_cnt != 4'd0) | hold_busy;

  always @(negedge clk) begin
    if (uif.start_tx === 1'b1) begin
      n_echo++;
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL echo_unexpected: got data_to_tx=%02h, required no echo", uif.data_to_tx);
      end else begin
        exp_b = sb.pop_front();
        if (uif.data_to_tx !== exp_b) begin
          n_fail++;
          $display("FAIL echo_data: got %02h, required %02h", uif.data_to_tx, exp_b);
        end else begin
          $display("echo %02h ok", uif.data_to_tx);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end else begin
      $display("check %s = %0h ok", name, act);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic perr, input logic echo, input logic [7:0] e);
    @(negedge clk);
    uif.data_received = b;
    uif.parity_error  = perr;
    uif.rx_done       = 1'b1;
    if (echo) sb.push_back(e);
    @(negedge clk);
    uif.rx_done      = 1'b0;
    uif.parity_error = 1'b0;
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL echo_wait: got %0d echoes outstanding, required 0", sb.size());
    end
    repeat (2) @(negedge clk);
    for (i = 0; i < 50 && uif.tx_busy; i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset             = 1'b1;
    uif.data_received = 8'h00;
    uif.rx_done       = 1'b0;
    uif.parity_error  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_stage_en", stage_en, 0);
    chk("rst_start_tx", uif.start_tx, 0);
    chk("rst_data_to_tx", uif.data_to_tx, 0);
    chk("rst_cmd_count", cmd_count, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_flags", {overrun, timeout_flag}, 0);
    reset = 1'b0;

    // turn on: stage_en two edges after rx_done, echo on the third
    send(8'hEE, 1'b0, 1'b1, 8'hEE);
    chk("on_stage_before", stage_en, 0);
    @(negedge clk);
    chk("on_stage_after", stage_en, 1);
    chk("on_start_not_yet", uif.start_tx, 0);
    @(negedge clk);
    chk("on_start_tx", uif.start_tx, 1);
    wait_done();
    chk("on_cmd_count", cmd_count, 1);

    send(8'hC3, 1'b0, 1'b1, 8'hC3);
    wait_done();
    chk("toggle1_stage", stage_en, 0);
    send(8'hC3, 1'b0, 1'b1, 8'hC3);
    wait_done();
    chk("toggle2_stage", stage_en, 1);
    chk("toggle_cmd_count", cmd_count, 3);

    // unknown byte is NACKed with its complement; parity error is silent
    send(8'hA5, 1'b0, 1'b1, 8'h5A);
    wait_done();
    chk("unknown_stage", stage_en, 1);
    chk("unknown_err", err_count, 1);
    send(8'h55, 1'b1, 1'b0, 8'h00);
    chk("parity_err", err_count, 2);
    repeat (8) @(negedge clk);
    chk("parity_stage", stage_en, 1);
    chk("parity_cmd_count", cmd_count, 3);

    // busy link: one decoded, one buffered, one dropped
    do_reset();
    hold_busy = 1'b1;
    e0 = n_echo;
    send(8'hEE, 1'b0, 1'b1, 8'hEE);
    send(8'hC3, 1'b0, 1'b1, 8'hC3);
    send(8'h55, 1'b0, 1'b0, 8'h00);
    chk("ovr_flag", overrun, 1);
    repeat (10) @(negedge clk);
    chk("ovr_no_echo_while_busy", n_echo - e0, 0);
    hold_busy = 1'b0;
    wait_done();
    chk("ovr_echo_count", n_echo - e0, 2);
    chk("ovr_stage", stage_en, 0);
    chk("ovr_cmd_count", cmd_count, 2);
    chk("ovr_err_count", err_count, 0);
    chk("ovr_sticky", overrun, 1);

    // watchdog
    do_reset();
    send(8'hEE, 1'b0, 1'b1, 8'hEE);
    hi = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (stage_en) hi++;
      else if (hi != 0) break;
    end
    chk("wd_on_cycles", hi, TMO);
    chk("wd_flag", timeout_flag, 1);
    chk("wd_stage_off", stage_en, 0);
    send(8'hEE, 1'b0, 1'b1, 8'hEE);
    @(negedge clk);
    chk("wd_stage_back", stage_en, 1);
    chk("wd_flag_cleared", timeout_flag, 0);
    wait_done();
    chk("wd_cmd_count", cmd_count, 2);

    // tx_busy never rises: give up after BUSY_WAIT cycles
    do_reset();
    model_en = 1'b0;
    send(8'hC3, 1'b0, 1'b1, 8'hC3);
    repeat (10) @(negedge clk);
    chk("ack_err_before", err_count, 0);
    @(negedge clk);
    chk("ack_err_after", err_count, 1);
    model_en = 1'b1;
    send(8'h55, 1'b0, 1'b1, 8'h55);
    wait_done();
    chk("ack_recover_cmd", cmd_count, 2);
    chk("ack_recover_stage", stage_en, 0);

    // asynchronous reset while waiting in TX_WAIT
    hold_busy = 1'b1;
    send(8'hEE, 1'b0, 1'b1, 8'hEE);
    repeat (3) @(negedge clk);
    chk("arst_pre_stage", stage_en, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_stage", stage_en, 0);
    chk("arst_start_tx", uif.start_tx, 0);
    chk("arst_data_to_tx", uif.data_to_tx, 0);
    chk("arst_counts", {cmd_count, err_count}, 0);
    chk("arst_flags", {overrun, timeout_flag}, 0);
    sb.delete();
    @(negedge clk);
    reset     = 1'b0;
    hold_busy = 1'b0;
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
